// File: rtl/mem_access_sequencer.sv
// Sequences EXE/MEM data accesses onto a 32-bit req/ack memory bus,
// splitting doubles into two beats and assembling/extending load data.
//
// state   | meaning
// IDLE    | waiting for a pending access; alignment decided here
// BEAT_LO | first (or only) bus beat outstanding
// BEAT_HI | upper word of a double access outstanding
// DONE    | one cycle with stall low so the pipeline advances
module mem_access_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              byte_in,
  input  logic              double_in,
  input  logic [63:0]       addr_in,
  input  logic [63:0]       store_data_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic [63:0]       load_data,
  output logic              load_valid,
  output logic              misalign_err,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, BEAT_LO, BEAT_HI, DONE} state_t;

  state_t      state, state_nxt;
  logic        pending, aligned, acked, tmo_hit;
  logic        is_byte, is_double;
  logic [7:0]  tmo_cnt;
  logic [31:0] lo_word;
  logic [31:0] hi_wdata;
  logic        op_byte, op_double, op_write;
  logic [1:0]  op_lane;
  logic [7:0]  rd_byte;
  logic [63:0] load_ext;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^addr_in[63:ADDR_W];

  // A double request takes precedence over the byte flag.
  assign is_double = double_in;
  assign is_byte   = byte_in & ~double_in;
  assign pending   = mem_read_in | mem_write_in;
  assign acked     = mem_req & mem_ack;
  assign tmo_hit   = mem_req & ~mem_ack & (tmo_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    aligned = 1'b1;
    if (is_double)
      aligned = (addr_in[2:0] == 3'b000);
    else if (!is_byte)
      aligned = (addr_in[1:0] == 2'b00);
  end

  always_comb begin
    rd_byte = mem_rdata[7:0];
    case (op_lane)
      2'd0: rd_byte = mem_rdata[7:0];
      2'd1: rd_byte = mem_rdata[15:8];
      2'd2: rd_byte = mem_rdata[23:16];
      2'd3: rd_byte = mem_rdata[31:24];
      default: rd_byte = mem_rdata[7:0];
    endcase
  end

  always_comb begin
    load_ext = {{32{mem_rdata[31]}}, mem_rdata};
    if (op_double)
      load_ext = {mem_rdata, lo_word};
    else if (op_byte)
      load_ext = {{56{rd_byte[7]}}, rd_byte};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          stall     = 1'b1;
          state_nxt = aligned ? BEAT_LO : DONE;
        end
      end
      BEAT_LO: begin
        stall = 1'b1;
        if (acked)        state_nxt = op_double ? BEAT_HI : DONE;
        else if (tmo_hit) state_nxt = DONE;
      end
      BEAT_HI: begin
        stall = 1'b1;
        if (acked || tmo_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      load_data    <= '0;
      load_valid   <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      tmo_cnt      <= '0;
      lo_word      <= '0;
      hi_wdata     <= '0;
      op_byte      <= 1'b0;
      op_double    <= 1'b0;
      op_write     <= 1'b0;
      op_lane      <= '0;
    end else begin
      load_valid   <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (pending && aligned) begin
            mem_req   <= 1'b1;
            mem_we    <= mem_write_in;
            mem_addr  <= addr_in[ADDR_W-1:0];
            mem_wdata <= is_byte ? {4{store_data_in[7:0]}} : store_data_in[31:0];
            mem_be    <= is_byte ? (4'b0001 << addr_in[1:0]) : 4'hF;
            tmo_cnt   <= '0;
            hi_wdata  <= store_data_in[63:32];
            op_byte   <= is_byte;
            op_double <= is_double;
            op_write  <= mem_write_in;
            op_lane   <= addr_in[1:0];
          end else if (pending) begin
            misalign_err <= 1'b1;
          end
        end
        BEAT_LO, BEAT_HI: begin
          if (acked) begin
            tmo_cnt <= '0;
            if (state == BEAT_LO && op_double) begin
              lo_word   <= mem_rdata;
              mem_addr  <= mem_addr + ADDR_W'(4);
              mem_wdata <= hi_wdata;
            end else begin
              mem_req <= 1'b0;
              if (!op_write) begin
                load_valid <= 1'b1;
                load_data  <= load_ext;
              end
            end
          end else if (tmo_hit) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
